// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with optional 2-entry skid buffer, flush and saturating stall counter
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic accept, consume;
  assign accept  = in_valid & in_ready & ~flush;
  assign consume = out_valid & out_ready;
  if (SKID != 0) begin : g_skid
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    logic [1:0]        state, st_n;
    logic              rdy_q, ld_in, ld_skid;
    logic [DATA_W-1:0] main_q, skid_q;
    always_comb begin
      st_n = flush ? EMPTY :
             state == EMPTY ? (accept ? ONE : EMPTY) :
             state == ONE   ? (accept & ~consume ? TWO : ~accept & consume ? EMPTY : ONE) :
                              (consume ? ONE : TWO);
      ld_in   = accept & (state == EMPTY | consume);
      ld_skid = (state == TWO) & consume;
    end
    // in_ready is registered from the next state so it never sees out_ready combinationally
    always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
        state  <= EMPTY;
        rdy_q  <= 1'b0;
        main_q <= '0;
        skid_q <= '0;
      end else begin
        state <= st_n;
        rdy_q <= st_n != TWO;
        if (ld_in) main_q <= in_data;
        else if (ld_skid) main_q <= skid_q;
        if ((state == ONE) & accept & ~consume) skid_q <= in_data;
      end
    end
    assign in_ready  = rdy_q;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign occupancy = state;
  end else begin : g_reg
    logic              v_q;
    logic [DATA_W-1:0] main_q;
    always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
        v_q    <= 1'b0;
        main_q <= '0;
      end else begin
        v_q <= flush ? 1'b0 : accept ? 1'b1 : consume ? 1'b0 : v_q;
        if (accept) main_q <= in_data;
      end
    end
    assign in_ready  = ~v_q | out_ready;
    assign out_valid = v_q;
    assign out_data  = main_q;
    assign occupancy = {1'b0, v_q};
  end
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~flush & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
